counter_checker: RTL and testbench

//  Passive cycle-accurate checker for the 8-bit up/down counter interface.

---
 rtl/counter_checker.sv | 144 ++++++++++++++
 tb/tb_counter_checker.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive cycle-accurate checker for the 8-bit up/down counter
// Runs a reference counter from the snooped controls and flags any disagreement.
module counter_checker #(
    parameter int WIDTH       = 8,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk_in,
    input  logic             nrst_in,
    input  logic             en_ctrl_in,
    input  logic             set_ctrl_in,
    input  logic             up_ctrl_in,
    input  logic [WIDTH-1:0] counter_in,
    input  logic [WIDTH-1:0] dut_count_in,
    input  logic             dut_ovf_in,
    input  logic             chk_en_in,
    input  logic             clr_err_in,
    output logic             mismatch_out,
    output logic [ERR_W-1:0] err_cnt_out,
    output logic [WIDTH:0]   first_exp_out,
    output logic [WIDTH:0]   first_got_out,
    output logic [1:0]       state_out,
    output logic             pass_out
);

    localparam logic [1:0] S_WAIT  = 2'b00;
    localparam logic [1:0] S_TRACK = 2'b01;
    localparam logic [1:0] S_FAIL  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_in_track;
    logic             w_in_fail;
    logic             w_stop;

    logic [WIDTH-1:0] r_exp_cnt;
    logic             r_exp_ovf;
    logic [WIDTH-1:0] w_step_cnt;
    logic             w_step_ovf;
    logic             w_mis;

    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_cnt;
    logic [WIDTH:0]   r_first_exp;
    logic [WIDTH:0]   r_first_got;
    logic             r_captured;

    assign w_stop = (STOP_ON_ERR != 0);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A clear on the same edge as a mismatch keeps the checker in TRACK.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:  w_next_state = S_TRACK;
            S_TRACK: if (w_stop && w_mis && !clr_err_in) w_next_state = S_FAIL;
            S_FAIL:  if (clr_err_in) w_next_state = S_TRACK;
            default: w_next_state = S_WAIT;
        endcase
    end

    always_comb begin
        w_in_track = (r_state == S_TRACK);
        w_in_fail  = (r_state == S_FAIL);
        state_out  = r_state;
        pass_out   = w_in_track && (r_err_cnt == '0);
    end

    // Reference counter: next value the real counter registers on this edge.
    always_comb begin
        w_step_cnt = r_exp_cnt;
        w_step_ovf = 1'b0;
        if (en_ctrl_in) begin
            if (set_ctrl_in) begin
                w_step_cnt = counter_in;
            end else if (up_ctrl_in) begin
                w_step_cnt = r_exp_cnt + 1'b1;
                w_step_ovf = &r_exp_cnt;
            end else begin
                w_step_cnt = r_exp_cnt - 1'b1;
                w_step_ovf = ~|r_exp_cnt;
            end
        end
    end

    assign w_mis = w_in_track && chk_en_in &&
                   ({dut_ovf_in, dut_count_in} != {r_exp_ovf, r_exp_cnt});

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_exp_cnt <= '0;
            r_exp_ovf <= 1'b0;
        end else if (w_in_fail) begin
            if (clr_err_in) begin
                r_exp_cnt <= dut_count_in;
                r_exp_ovf <= 1'b0;
            end
        end else begin
            r_exp_cnt <= w_step_cnt;
            r_exp_ovf <= w_step_ovf;
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_mismatch  <= 1'b0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_captured  <= 1'b0;
        end else begin
            r_mismatch <= w_mis;
            if (clr_err_in) begin
                r_err_cnt   <= '0;
                r_first_exp <= '0;
                r_first_got <= '0;
                r_captured  <= 1'b0;
            end else if (w_mis) begin
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_captured) begin
                    r_first_exp <= {r_exp_ovf, r_exp_cnt};
                    r_first_got <= {dut_ovf_in, dut_count_in};
                    r_captured  <= 1'b1;
                end
            end
        end
    end

    assign mismatch_out  = r_mismatch;
    assign err_cnt_out   = r_err_cnt;
    assign first_exp_out = r_first_exp;
    assign first_got_out = r_first_got;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - self-checking bench for counter_checker
// Three checker instances (default, stop-on-error, 2-bit error count) share one snooped counter.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, set = 1'b0, up = 1'b0, chk = 1'b0, clr = 1'b0;
    logic [7:0] load = '0, dcnt = '0;
    logic       dovf = 1'b0;

    logic       mis0, mis1, mis2, pass0, pass1, pass2;
    logic [7:0] err0, err1;
    logic [1:0] err2, st0, st1, st2;
    logic [8:0] fe0, fg0, fe1, fg1, fe2, fg2;
    logic [29:0] obs [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Golden counter driven onto dut_count_in/dut_ovf_in (optionally corrupted).
    int g_cnt, g_ovf;
    // Per-instance expected checker behaviour.
    int m_st[3], m_cnt[3], m_ovf[3], m_err[3], m_fe[3], m_fg[3], m_lock[3], m_pulse[3];
    int ERRMAX[3] = '{255, 255, 3};
    int STOPC[3]  = '{0, 1, 0};

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(8), .ERR_W(8), .STOP_ON_ERR(0)) u_def (
        .clk_in(clk), .nrst_in(rst_n), .en_ctrl_in(en), .set_ctrl_in(set), .up_ctrl_in(up),
        .counter_in(load), .dut_count_in(dcnt), .dut_ovf_in(dovf), .chk_en_in(chk), .clr_err_in(clr),
        .mismatch_out(mis0), .err_cnt_out(err0), .first_exp_out(fe0), .first_got_out(fg0),
        .state_out(st0), .pass_out(pass0));

    counter_checker #(.WIDTH(8), .ERR_W(8), .STOP_ON_ERR(1)) u_stop (
        .clk_in(clk), .nrst_in(rst_n), .en_ctrl_in(en), .set_ctrl_in(set), .up_ctrl_in(up),
        .counter_in(load), .dut_count_in(dcnt), .dut_ovf_in(dovf), .chk_en_in(chk), .clr_err_in(clr),
        .mismatch_out(mis1), .err_cnt_out(err1), .first_exp_out(fe1), .first_got_out(fg1),
        .state_out(st1), .pass_out(pass1));

    counter_checker #(.WIDTH(8), .ERR_W(2), .STOP_ON_ERR(0)) u_sat (
        .clk_in(clk), .nrst_in(rst_n), .en_ctrl_in(en), .set_ctrl_in(set), .up_ctrl_in(up),
        .counter_in(load), .dut_count_in(dcnt), .dut_ovf_in(dovf), .chk_en_in(chk), .clr_err_in(clr),
        .mismatch_out(mis2), .err_cnt_out(err2), .first_exp_out(fe2), .first_got_out(fg2),
        .state_out(st2), .pass_out(pass2));

    assign obs[0] = {mis0, err0, st0, pass0, fe0, fg0};
    assign obs[1] = {mis1, err1, st1, pass1, fe1, fg1};
    assign obs[2] = {mis2, 6'b0, err2, st2, pass2, fe2, fg2};

    function automatic int step_cnt(int c, bit e, bit s, bit u, int ld);
        if (!e) return c;
        if (s)  return ld;
        if (u)  return (c + 1) % 256;
        return (c + 255) % 256;
    endfunction

    function automatic int step_ovf(int c, bit e, bit s, bit u);
        if (!e || s) return 0;
        if (u) return (c == 255) ? 1 : 0;
        return (c == 0) ? 1 : 0;
    endfunction

    function automatic logic [29:0] exp_vec(int i);
        logic [7:0] e8;
        logic [1:0] s2;
        logic [8:0] fe, fg;
        logic p, pl;
        e8 = 8'(m_err[i]);
        s2 = 2'(m_st[i]);
        fe = 9'(m_fe[i]);
        fg = 9'(m_fg[i]);
        p  = (m_st[i] == 1) && (m_err[i] == 0);
        pl = (m_pulse[i] != 0);
        return {pl, e8, s2, p, fe, fg};
    endfunction

    task automatic model_reset();
        g_cnt = 0;
        g_ovf = 0;
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
            m_fe[i] = 0; m_fg[i] = 0; m_lock[i] = 0; m_pulse[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0; set = 0; up = 0; load = 0; chk = 0; clr = 0;
        dcnt = 0; dovf = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, update expectations, return at the next negedge.
    task automatic cycle(input bit e, input bit s, input bit u, input int ld,
                         input int xc, input bit xo, input bit ck, input bit cl);
        int dcv, dov, nc, no;
        bit mis;
        dcv = (g_cnt ^ xc) & 255;
        dov = g_ovf ^ int'(xo);
        en = e; set = s; up = u; load = 8'(ld); chk = ck; clr = cl;
        dcnt = 8'(dcv); dovf = dov[0];
        for (int i = 0; i < 3; i++) begin
            mis = 1'b0;
            nc = step_cnt(m_cnt[i], e, s, u, ld);
            no = step_ovf(m_cnt[i], e, s, u);
            if (m_st[i] == 0) begin
                m_st[i] = 1;
                m_cnt[i] = nc; m_ovf[i] = no;
            end else if (m_st[i] == 1) begin
                mis = ck && ((dcv != m_cnt[i]) || (dov != m_ovf[i]));
                if (cl) begin
                    m_err[i] = 0; m_fe[i] = 0; m_fg[i] = 0; m_lock[i] = 0;
                end else if (mis) begin
                    if (m_err[i] < ERRMAX[i]) m_err[i]++;
                    if (m_lock[i] == 0) begin
                        m_fe[i] = m_ovf[i] * 256 + m_cnt[i];
                        m_fg[i] = dov * 256 + dcv;
                        m_lock[i] = 1;
                    end
                    if (STOPC[i] != 0) m_st[i] = 2;
                end
                m_cnt[i] = nc; m_ovf[i] = no;
            end else if (cl) begin
                m_st[i] = 1;
                m_cnt[i] = dcv; m_ovf[i] = 0;
                m_err[i] = 0; m_fe[i] = 0; m_fg[i] = 0; m_lock[i] = 0;
            end
            m_pulse[i] = mis ? 1 : 0;
        end
        g_ovf = step_ovf(g_cnt, e, s, u);
        g_cnt = step_cnt(g_cnt, e, s, u, ld);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs[i] !== 30'h0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d got %h exp %h", i, obs[i], 30'h0);
            end
        end
        release_reset();
    endtask

    task automatic test_count_up();
        do_reset();
        release_reset();
        for (int c = 0; c < 300; c++) begin
            cycle(1, 0, 1, 0, 0, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL count_up inst%0d cyc%0d got %h exp %h", i, c, obs[i], exp_vec(i));
                end
            end
        end
        n_tests++;
        if (pass0 !== 1'b1 || err0 !== 8'd0) begin
            n_fail++;
            $display("FAIL count_up_pass got pass=%b err=%0d exp pass=1 err=0", pass0, err0);
        end
    endtask

    task automatic test_load_down();
        do_reset();
        release_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 1, 0, 8'h05, 0, 0, 1, 0);
        for (int c = 0; c < 7; c++) begin
            if (c < 6) cycle(1, 0, 0, 0, 0, 0, 1, 0);
            else       cycle(0, 0, 0, 0, 0, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL load_down inst%0d step%0d got %h exp %h", i, c, obs[i], exp_vec(i));
                end
            end
        end
        n_tests++;
        if (err0 !== 8'd0 || dcnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL load_down_end got err=%0d cnt=%h exp err=0 cnt=ff", err0, dcnt);
        end
    endtask

    task automatic test_forced_mismatch();
        do_reset();
        release_reset();
        cycle(1, 1, 0, 8'h11, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 8'h01, 0, 1, 0);
        n_tests++;
        if (mis0 !== 1'b1 || err0 !== 8'd1 || fe0 !== 9'h011 || fg0 !== 9'h010) begin
            n_fail++;
            $display("FAIL forced_mismatch got mis=%b err=%0d fe=%h fg=%h exp mis=1 err=1 fe=011 fg=010",
                     mis0, err0, fe0, fg0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        n_tests++;
        if (mis0 !== 1'b0 || err0 !== 8'd1 || pass0 !== 1'b0) begin
            n_fail++;
            $display("FAIL forced_pulse_width got mis=%b err=%0d pass=%b exp mis=0 err=1 pass=0",
                     mis0, err0, pass0);
        end
    endtask

    task automatic test_stop_on_err();
        do_reset();
        release_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 8'h03, 0, 1, 0);
        n_tests++;
        if (st1 !== 2'b10 || mis1 !== 1'b1 || st0 !== 2'b01) begin
            n_fail++;
            $display("FAIL stop_enter got st1=%b mis1=%b st0=%b exp 10 1 01", st1, mis1, st0);
        end
        cycle(1, 1, 0, 8'h40, 8'h5A, 0, 1, 0);
        n_tests++;
        if (mis1 !== 1'b0 || st1 !== 2'b10 || err1 !== 8'd1) begin
            n_fail++;
            $display("FAIL stop_frozen got mis1=%b st1=%b err1=%0d exp 0 10 1", mis1, st1, err1);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        n_tests++;
        if (st1 !== 2'b01 || err1 !== 8'd0) begin
            n_fail++;
            $display("FAIL stop_clear got st1=%b err1=%0d exp 01 0", st1, err1);
        end
        cycle(1, 0, 1, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 8'h01, 0, 1, 0);
        n_tests++;
        if (mis1 !== 1'b1 || fe1 !== 9'h041 || fg1 !== 9'h040) begin
            n_fail++;
            $display("FAIL stop_resync got mis1=%b fe1=%h fg1=%h exp 1 041 040", mis1, fe1, fg1);
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        do_reset();
        release_reset();
        cycle(1, 1, 0, 8'h20, 0, 0, 1, 0);
        for (int c = 0; c < 5; c++) begin
            cycle(1, 0, 1, 0, 8'h80, 0, 1, 0);
            if (mis2 === 1'b1) pulses++;
        end
        n_tests++;
        if (err2 !== 2'd3 || pulses != 5) begin
            n_fail++;
            $display("FAIL saturate got err2=%0d pulses=%0d exp 3 5", err2, pulses);
        end
        n_tests++;
        if (fe2 !== 9'h020 || fg2 !== 9'h0A0 || err0 !== 8'd5) begin
            n_fail++;
            $display("FAIL saturate_first got fe2=%h fg2=%h err0=%0d exp 020 0a0 5", fe2, fg2, err0);
        end
    endtask

    task automatic test_chk_disable();
        int pulses = 0;
        do_reset();
        release_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            cycle(1, 0, 1, 0, $urandom_range(1, 255), 1'($urandom_range(0, 1)), 0, 0);
            if (mis0 !== 1'b0 || mis1 !== 1'b0) pulses++;
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1, 0, 1, 0, 0, 0, 1, 0);
            if (mis0 !== 1'b0 || mis1 !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses != 0 || err0 !== 8'd0 || pass0 !== 1'b1 || st1 !== 2'b01) begin
            n_fail++;
            $display("FAIL chk_disable got pulses=%0d err0=%0d pass0=%b st1=%b exp 0 0 1 01",
                     pulses, err0, pass0, st1);
        end
    endtask

    task automatic test_clear_same_edge();
        do_reset();
        release_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 8'h07, 0, 1, 0);
        cycle(0, 0, 0, 0, 8'h09, 0, 1, 1);
        n_tests++;
        if (mis0 !== 1'b1 || err0 !== 8'd0 || fe0 !== 9'h0 || fg0 !== 9'h0) begin
            n_fail++;
            $display("FAIL clear_same_edge got mis=%b err=%0d fe=%h fg=%h exp 1 0 000 000",
                     mis0, err0, fe0, fg0);
        end
    endtask

    task automatic test_random();
        do_reset();
        release_reset();
        for (int c = 0; c < 400; c++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), $urandom_range(0, 255),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 255) : 0,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d got %h exp %h", i, c, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 1, 0, 8'h33, 0, 1, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs[i] !== 30'h0) begin
                n_fail++;
                $display("FAIL reset_midrun inst%0d got %h exp %h", i, obs[i], 30'h0);
            end
        end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_forced_mismatch();
        test_stop_on_err();
        test_saturate();
        test_chk_disable();
        test_clear_same_edge();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
